nn_result_ctrl: RTL and testbench

Sequencer for one inference of the two-output backpropagation network and its LED result display. Launches the network on a user start pulse, waits for the network's done pulse with a timeout, and latches the two output-layer activations. It then drives LED0/LED1 from a margin-aware comparison of those activations and holds the result until the next start. It sits between the board push-button/synchroniser logic and the network top, replacing a free-running combinational LED compare.

---
 rtl/nn_ctrl_pkg.sv | 31 +++
 rtl/nn_result_ctrl_margin_comp.sv | 38 +++
 rtl/nn_result_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_nn_result_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_ctrl_pkg
// Description : Shared definitions for the network-control blocks. Holds the
//               sequencer state encoding, the default activation width and
//               a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_ctrl_pkg;

    // Default width of one output-layer activation (unsigned).
    localparam int NN_DATA_W = 16;

    // Sequencer state encoding.
    localparam int ST_W = 3;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RUN     = 3'd1;
    localparam state_t ST_CAPTURE = 3'd2;
    localparam state_t ST_SHOW    = 3'd3;
    localparam state_t ST_ERR     = 3'd4;

    // Counter width for a count range of n. This is $clog2(n), but never less
    // than one bit, so that n = 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nn_result_ctrl_margin_comp.sv
`default_nettype none
// ============================================================================
// Module      : margin_comp
// Description : Margin-aware comparison of two unsigned activations.
//               gt  : a > b
//               tie : |a - b| <= margin
// Ports       : a, b    - activations to compare (DATA_W, unsigned)
//               margin  - ambiguity band (DATA_W, unsigned)
//               gt, tie - comparison results (purely combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module margin_comp
    import nn_ctrl_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] margin,
    output logic              gt,
    output logic              tie
);

    localparam logic [DATA_W:0] c_ONE = (DATA_W+1)'(1);

    logic [DATA_W:0] w_diff;
    logic [DATA_W:0] w_mag;

    // The difference is held in DATA_W+1 bits as two's complement. Because
    // both operands are unsigned, the magnitude always fits without overflow.
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_mag  = w_diff[DATA_W] ? (~w_diff + c_ONE) : w_diff;

    assign gt  = (a > b);
    assign tie = (w_mag <= {1'b0, margin});

endmodule
`default_nettype wire

// File: rtl/nn_result_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nn_result_ctrl
// Description : Sequencer for one network inference and its LED result.
//               A start pulse launches the network, which is then timed out
//               if its done pulse never arrives. The two activations are
//               latched on done, compared with a margin, and the result is
//               shown on LED0/LED1 until the next start.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start               - request an inference (one cycle)
//               nn_done, a3_1, a3_2 - network completion and activations
//               nn_start            - one-cycle launch pulse to the network
//               busy, result_valid, result_tie, timeout_err - status
//               LED0, LED1          - class / blink indicators
// Revision    : 1.0 - initial release
// ============================================================================
module nn_result_ctrl
    import nn_ctrl_pkg::*;
#(
    parameter int                DATA_W     = NN_DATA_W,
    parameter logic [DATA_W-1:0] MARGIN     = '0,
    parameter int                TIMEOUT    = 1_000_000,
    parameter int                BLINK_HALF = 12_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              nn_done,
    input  logic [DATA_W-1:0] a3_1,
    input  logic [DATA_W-1:0] a3_2,
    output logic              nn_start,
    output logic              busy,
    output logic              result_valid,
    output logic              result_tie,
    output logic              timeout_err,
    output logic              LED0,
    output logic              LED1
);

    localparam int TO_W = cnt_width(TIMEOUT);
    localparam int BL_W = cnt_width(BLINK_HALF);

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] c_TO_ONE  = TO_W'(1);
    localparam logic [BL_W-1:0] c_BL_LAST = BL_W'(BLINK_HALF - 1);
    localparam logic [BL_W-1:0] c_BL_ONE  = BL_W'(1);

    // Registered state
    state_t            r_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic [BL_W-1:0]   r_bl_cnt;
    logic              r_phase;
    logic [DATA_W-1:0] r_a1;
    logic [DATA_W-1:0] r_a2;
    logic              r_nn_start;
    logic              r_busy;
    logic              r_valid;
    logic              r_tie;
    logic              r_err;
    logic              r_led0;
    logic              r_led1;

    // Next-state values
    state_t            w_state;
    logic [TO_W-1:0]   w_to_cnt;
    logic [BL_W-1:0]   w_bl_cnt;
    logic              w_phase;
    logic [DATA_W-1:0] w_a1;
    logic [DATA_W-1:0] w_a2;
    logic              w_enter_run;
    logic              w_nn_start;
    logic              w_busy;
    logic              w_valid;
    logic              w_tie;
    logic              w_err;
    logic              w_led0;
    logic              w_led1;

    logic              w_gt;
    logic              w_cmp_tie;

    // The comparison runs on the latched activations, so its result is
    // meaningful in the CAPTURE cycle that follows the latch.
    margin_comp #(
        .DATA_W (DATA_W)
    ) u_margin_comp (
        .a      (r_a1),
        .b      (r_a2),
        .margin (MARGIN),
        .gt     (w_gt),
        .tie    (w_cmp_tie)
    );

    always_comb begin
        w_state    = r_state;
        w_to_cnt   = '0;
        w_bl_cnt   = '0;
        w_phase    = 1'b0;
        w_a1       = r_a1;
        w_a2       = r_a2;
        w_led0     = r_led0;
        w_led1     = r_led1;
        w_tie      = 1'b0;

        case (r_state)
            ST_IDLE, ST_SHOW, ST_ERR: begin
                if (start) begin
                    w_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // Done takes priority over an expiring timeout.
                if (nn_done) begin
                    w_a1    = a3_1;
                    w_a2    = a3_2;
                    w_state = ST_CAPTURE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_state = ST_ERR;
                end
            end
            ST_CAPTURE: begin
                w_state = ST_SHOW;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_enter_run = (w_state == ST_RUN) && (r_state != ST_RUN);

        // The timeout counter equals the number of RUN cycles already spent.
        if ((w_state == ST_RUN) && !w_enter_run) begin
            w_to_cnt = r_to_cnt + c_TO_ONE;
        end

        // The blink phase restarts at 0 on every entry to RUN or ERR and
        // toggles after each BLINK_HALF cycles spent in that state.
        if (((w_state == ST_RUN) || (w_state == ST_ERR)) && (w_state == r_state)) begin
            if (r_bl_cnt == c_BL_LAST) begin
                w_bl_cnt = '0;
                w_phase  = ~r_phase;
            end else begin
                w_bl_cnt = r_bl_cnt + c_BL_ONE;
                w_phase  = r_phase;
            end
        end

        // Outputs are decoded from the next state and then registered, which
        // keeps every input-to-output path behind a flop.
        w_nn_start = w_enter_run;
        w_busy     = (w_state == ST_RUN) || (w_state == ST_CAPTURE);
        w_valid    = (w_state == ST_SHOW);
        w_err      = (w_state == ST_ERR);

        case (w_state)
            ST_RUN: begin
                w_led0 = w_phase;
                w_led1 = w_phase;
            end
            ST_CAPTURE: begin
                // LEDs hold their last blink value for this single cycle.
            end
            ST_SHOW: begin
                if (r_state == ST_CAPTURE) begin
                    w_led0 = w_cmp_tie | w_gt;
                    w_led1 = w_cmp_tie | ~w_gt;
                    w_tie  = w_cmp_tie;
                end else begin
                    w_tie  = r_tie;
                end
            end
            ST_ERR: begin
                w_led0 = w_phase;
                w_led1 = 1'b0;
            end
            default: begin
                w_led0 = 1'b0;
                w_led1 = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_to_cnt   <= '0;
            r_bl_cnt   <= '0;
            r_phase    <= 1'b0;
            r_a1       <= '0;
            r_a2       <= '0;
            r_nn_start <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_tie      <= 1'b0;
            r_err      <= 1'b0;
            r_led0     <= 1'b0;
            r_led1     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_to_cnt   <= w_to_cnt;
            r_bl_cnt   <= w_bl_cnt;
            r_phase    <= w_phase;
            r_a1       <= w_a1;
            r_a2       <= w_a2;
            r_nn_start <= w_nn_start;
            r_busy     <= w_busy;
            r_valid    <= w_valid;
            r_tie      <= w_tie;
            r_err      <= w_err;
            r_led0     <= w_led0;
            r_led1     <= w_led1;
        end
    end

    assign nn_start     = r_nn_start;
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign result_tie   = r_tie;
    assign timeout_err  = r_err;
    assign LED0         = r_led0;
    assign LED1         = r_led1;

endmodule
`default_nettype wire

// File: tb/tb_nn_result_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_result_ctrl
// Description : Self-checking bench for nn_result_ctrl. Two instances share
//               their stimulus: one uses MARGIN = 16'h0100, the other uses
//               MARGIN = 0. Expected results come from a plain arithmetic
//               model of the classification and blink rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_result_ctrl;

    localparam int          TO   = 50;
    localparam int          BH   = 3;
    localparam logic [15:0] MRG  = 16'h0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        nn_done = 1'b0;
    logic [15:0] a3_1 = '0;
    logic [15:0] a3_2 = '0;

    logic nn_start, busy, result_valid, result_tie, timeout_err, LED0, LED1;
    logic nn_start_z, busy_z, result_valid_z, result_tie_z, timeout_err_z, LED0_z, LED1_z;

    int checks = 0;
    int errors = 0;
    int ns_count = 0;

    nn_result_ctrl #(
        .DATA_W(16), .MARGIN(MRG), .TIMEOUT(TO), .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .nn_done(nn_done),
        .a3_1(a3_1), .a3_2(a3_2),
        .nn_start(nn_start), .busy(busy), .result_valid(result_valid),
        .result_tie(result_tie), .timeout_err(timeout_err),
        .LED0(LED0), .LED1(LED1)
    );

    nn_result_ctrl #(
        .DATA_W(16), .MARGIN(16'd0), .TIMEOUT(TO), .BLINK_HALF(BH)
    ) dut_z (
        .clk(clk), .rst(rst), .start(start), .nn_done(nn_done),
        .a3_1(a3_1), .a3_2(a3_2),
        .nn_start(nn_start_z), .busy(busy_z), .result_valid(result_valid_z),
        .result_tie(result_tie_z), .timeout_err(timeout_err_z),
        .LED0(LED0_z), .LED1(LED1_z)
    );

    always #5 clk = ~clk;

    // Counts launch pulses of the main instance over the whole run.
    always @(posedge clk) if (nn_start === 1'b1) ns_count++;

    logic [6:0] outs;
    logic [2:0] res, res_z;
    assign outs  = {nn_start, busy, result_valid, result_tie, timeout_err, LED0, LED1};
    assign res   = {LED0, LED1, result_tie};
    assign res_z = {LED0_z, LED1_z, result_tie_z};

    // Reference classification: {LED0, LED1, tie}.
    function automatic logic [2:0] cls(input logic [15:0] x, input logic [15:0] y, input int m);
        int d;
        d = int'(x) - int'(y);
        if (d <= m && d >= -m) return 3'b111;
        else if (d > 0)        return 3'b100;
        else                   return 3'b010;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first RUN cycle.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Done pulse then CAPTURE; leaves the bench in the first SHOW cycle.
    task automatic finish_done(input logic [15:0] x, input logic [15:0] y);
        nn_done = 1'b1; a3_1 = x; a3_2 = y;
        tick();
        nn_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (outs !== 7'b0) begin errors++; $display("FAIL reset_hold: got %b want %b", outs, 7'b0); end
        rst = 1'b0;
        tick();
        checks++;
        if (outs !== 7'b0) begin errors++; $display("FAIL reset_idle: got %b want %b", outs, 7'b0); end
    endtask

    task automatic test_basic();
        int n0;
        n0 = ns_count;
        pulse_start();
        checks++;
        if (outs !== 7'b1100000) begin errors++; $display("FAIL basic_launch: got %b want %b", outs, 7'b1100000); end
        tick();
        checks++;
        if (outs[6:5] !== 2'b01) begin errors++; $display("FAIL basic_pulse_end: got %b want %b", outs[6:5], 2'b01); end
        repeat (9) tick();
        nn_done = 1'b1; a3_1 = 16'h3000; a3_2 = 16'h1000;
        tick();
        nn_done = 1'b0;
        checks++;
        if ({busy, result_valid} !== 2'b10) begin errors++; $display("FAIL basic_capture: got %b want %b", {busy, result_valid}, 2'b10); end
        tick();
        checks++;
        if (outs !== 7'b0010010) begin errors++; $display("FAIL basic_show: got %b want %b", outs, 7'b0010010); end
        checks++;
        if (res_z !== 3'b100) begin errors++; $display("FAIL basic_show_m0: got %b want %b", res_z, 3'b100); end
        checks++;
        if (ns_count - n0 !== 1) begin errors++; $display("FAIL basic_nn_start_count: got %0d want %0d", ns_count - n0, 1); end
    endtask

    task automatic test_blink();
        logic e;
        pulse_start();
        for (int k = 0; k < 21; k++) begin
            e = ((k / BH) % 2) == 1;
            checks++;
            if ({LED0, LED1} !== {e, e}) begin
                errors++; $display("FAIL blink_run k=%0d: got %b want %b", k, {LED0, LED1}, {e, e});
            end
            tick();
        end
        finish_done(16'h0010, 16'h9000);
        checks++;
        if (res !== 3'b010) begin errors++; $display("FAIL blink_result: got %b want %b", res, 3'b010); end
    endtask

    task automatic test_margin();
        logic [15:0] ys [3] = '{16'h2000, 16'h2200, 16'h2080};
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            repeat (3) tick();
            finish_done(16'h2080, ys[i]);
            checks++;
            if (res !== cls(16'h2080, ys[i], int'(MRG))) begin
                errors++; $display("FAIL margin_%0d: got %b want %b", i, res, cls(16'h2080, ys[i], int'(MRG)));
            end
            checks++;
            if (res_z !== cls(16'h2080, ys[i], 0)) begin
                errors++; $display("FAIL margin0_%0d: got %b want %b", i, res_z, cls(16'h2080, ys[i], 0));
            end
        end
    endtask

    task automatic test_timeout();
        int ones;
        pulse_start();
        repeat (TO - 1) tick();
        checks++;
        if ({busy, timeout_err} !== 2'b10) begin errors++; $display("FAIL timeout_last_run: got %b want %b", {busy, timeout_err}, 2'b10); end
        tick();
        checks++;
        if ({busy, result_valid, timeout_err, LED1} !== 4'b0010) begin
            errors++; $display("FAIL timeout_err: got %b want %b", {busy, result_valid, timeout_err, LED1}, 4'b0010);
        end
        nn_done = 1'b1; a3_1 = 16'hFFFF; a3_2 = 16'h0000;
        tick();
        nn_done = 1'b0;
        tick();
        checks++;
        if ({busy, result_valid, timeout_err, LED1} !== 4'b0010) begin
            errors++; $display("FAIL timeout_done_ignored: got %b want %b", {busy, result_valid, timeout_err, LED1}, 4'b0010);
        end
        ones = 0;
        for (int j = 0; j < 2 * BH; j++) begin
            ones += int'(LED0);
            tick();
        end
        checks++;
        if (ones !== BH) begin errors++; $display("FAIL timeout_blink: got %0d want %0d", ones, BH); end
        pulse_start();
        checks++;
        if ({nn_start, busy, timeout_err} !== 3'b110) begin
            errors++; $display("FAIL timeout_restart: got %b want %b", {nn_start, busy, timeout_err}, 3'b110);
        end
        finish_done(16'h0100, 16'h5000);
        checks++;
        if (res !== 3'b010) begin errors++; $display("FAIL timeout_rerun: got %b want %b", res, 3'b010); end
    endtask

    task automatic test_done_at_timeout();
        pulse_start();
        repeat (TO - 1) tick();
        nn_done = 1'b1; a3_1 = 16'h1234; a3_2 = 16'h1200;
        tick();
        nn_done = 1'b0;
        checks++;
        if ({busy, timeout_err} !== 2'b10) begin errors++; $display("FAIL edge_capture: got %b want %b", {busy, timeout_err}, 2'b10); end
        tick();
        checks++;
        if ({result_valid, timeout_err, res} !== {2'b10, cls(16'h1234, 16'h1200, int'(MRG))}) begin
            errors++; $display("FAIL edge_show: got %b want %b", {result_valid, timeout_err, res}, {2'b10, cls(16'h1234, 16'h1200, int'(MRG))});
        end
        checks++;
        if (res_z !== cls(16'h1234, 16'h1200, 0)) begin errors++; $display("FAIL edge_show_m0: got %b want %b", res_z, cls(16'h1234, 16'h1200, 0)); end
        repeat (3) tick();
        checks++;
        if ({result_valid, timeout_err} !== 2'b10) begin errors++; $display("FAIL edge_hold: got %b want %b", {result_valid, timeout_err}, 2'b10); end
    endtask

    task automatic test_ignore();
        int          n0;
        logic [2:0]  held;
        held = cls(16'h1234, 16'h1200, int'(MRG));
        n0 = ns_count;
        for (int i = 0; i < 3; i++) begin
            nn_done = 1'b1; a3_1 = 16'(i * 16'h4000); a3_2 = 16'hFFFF;
            tick();
        end
        nn_done = 1'b0;
        tick();
        checks++;
        if ({nn_start, result_valid, res} !== {2'b01, held}) begin
            errors++; $display("FAIL ignore_show: got %b want %b", {nn_start, result_valid, res}, {2'b01, held});
        end
        pulse_start();
        tick();
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if ({nn_start, busy} !== 2'b01) begin errors++; $display("FAIL ignore_run_start_%0d: got %b want %b", i, {nn_start, busy}, 2'b01); end
        end
        finish_done(16'h7000, 16'h0001);
        checks++;
        if (res !== 3'b100) begin errors++; $display("FAIL ignore_run_result: got %b want %b", res, 3'b100); end
        checks++;
        if (ns_count - n0 !== 1) begin errors++; $display("FAIL ignore_nn_start_count: got %0d want %0d", ns_count - n0, 1); end
        rst = 1'b1; tick(); rst = 1'b0; tick();
        nn_done = 1'b1; a3_1 = 16'hAAAA; a3_2 = 16'h5555;
        tick(); tick();
        nn_done = 1'b0;
        checks++;
        if (outs !== 7'b0) begin errors++; $display("FAIL ignore_idle: got %b want %b", outs, 7'b0); end
        pulse_start();
        finish_done(16'h0200, 16'h0250);
        checks++;
        if (res !== cls(16'h0200, 16'h0250, int'(MRG))) begin
            errors++; $display("FAIL ignore_after_idle: got %b want %b", res, cls(16'h0200, 16'h0250, int'(MRG)));
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        pulse_start();
        repeat (5) tick();
        n0 = ns_count;
        rst = 1'b1;
        tick();
        checks++;
        if (outs !== 7'b0 || res_z !== 3'b0) begin errors++; $display("FAIL rst_run: got %b want %b", outs, 7'b0); end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (outs !== 7'b0) begin errors++; $display("FAIL rst_run_idle: got %b want %b", outs, 7'b0); end
        checks++;
        if (ns_count !== n0) begin errors++; $display("FAIL rst_no_launch: got %0d want %0d", ns_count, n0); end
        pulse_start();
        checks++;
        if ({nn_start, busy} !== 2'b11) begin errors++; $display("FAIL rst_relaunch: got %b want %b", {nn_start, busy}, 2'b11); end
        finish_done(16'h4000, 16'h4000);
        checks++;
        if ({res, res_z} !== 6'b111111) begin errors++; $display("FAIL rst_equal_tie: got %b want %b", {res, res_z}, 6'b111111); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (outs !== 7'b0) begin errors++; $display("FAIL rst_show: got %b want %b", outs, 7'b0); end
    endtask

    task automatic test_random();
        logic [15:0] x, y;
        int          kd, off;
        for (int it = 0; it < 25; it++) begin
            x  = 16'($urandom);
            off = int'($urandom_range(0, 768)) - 384;
            y  = ($urandom_range(0, 1) == 1) ? 16'(int'(x) + off) : 16'($urandom);
            kd = int'($urandom_range(0, TO - 1));
            pulse_start();
            checks++;
            if ({nn_start, busy} !== 2'b11) begin errors++; $display("FAIL rand_%0d_launch: got %b want %b", it, {nn_start, busy}, 2'b11); end
            repeat (kd) tick();
            finish_done(x, y);
            checks++;
            if ({result_valid, timeout_err, res} !== {2'b10, cls(x, y, int'(MRG))}) begin
                errors++; $display("FAIL rand_%0d x=%h y=%h: got %b want %b", it, x, y, {result_valid, timeout_err, res}, {2'b10, cls(x, y, int'(MRG))});
            end
            checks++;
            if (res_z !== cls(x, y, 0)) begin
                errors++; $display("FAIL rand0_%0d x=%h y=%h: got %b want %b", it, x, y, res_z, cls(x, y, 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blink();
        test_margin();
        test_timeout();
        test_done_at_timeout();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
